// File: rtl/iiitb_tlc_pkg.sv
// Shared types and light codes for the four-way traffic-light scheduler.
// Also holds the light decoder used by the scheduler output stage.
package iiitb_tlc_pkg;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_GREEN  = 2'd1,
    S_YELLOW = 2'd2,
    S_ALLRED = 2'd3
  } tlc_state_t;

  localparam logic [2:0] RED = 3'b100;
  localparam logic [2:0] YEL = 3'b010;
  localparam logic [2:0] GRN = 3'b001;

  function automatic int max_of(int a, int b);
    return (a > b) ? a : b;
  endfunction

  // Only the granted approach ever shows a non-red aspect.
  function automatic logic [11:0] light_decode(tlc_state_t st, logic [1:0] g);
    logic [11:0] l;
    l = {4{RED}};
    for (int i = 0; i < 4; i++) begin
      if (g == 2'(i)) begin
        if (st == S_GREEN)
          l[3*i +: 3] = GRN;
        else if (st == S_YELLOW)
          l[3*i +: 3] = YEL;
      end
    end
    return l;
  endfunction

endpackage

// File: rtl/iiitb_tlc_tick.sv
// Timing prescaler: counts 0..TICK_DIV-1 and flags the last count as a tick.
// clr restarts the count so each phase begins on a whole tick boundary.
module iiitb_tlc_tick #(
  parameter int TICK_DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  output logic tick
);

  localparam int W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  logic [W-1:0] cnt;

  assign tick = (cnt == W'(TICK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else if (clr || tick)
      cnt <= '0;
    else
      cnt <= cnt + W'(1);
  end

endmodule

// File: rtl/iiitb_tlc_sched.sv
// Four-approach traffic-light scheduler with round-robin right-of-way,
// min/max green, yellow and all-red clearance timed in prescaled ticks.
module iiitb_tlc_sched
  import iiitb_tlc_pkg::*;
#(
  parameter int TICK_DIV = 4,
  parameter int T_GMIN   = 5,
  parameter int T_GMAX   = 10,
  parameter int T_YEL    = 3,
  parameter int T_ALLRED = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  req,
  output logic [11:0] light,
  output logic [1:0]  grant,
  output logic        busy
);

  // Phase counter must reach the last tick index of the longest phase.
  localparam int PH_MAX = max_of(max_of(T_GMIN, T_GMAX), max_of(T_YEL, T_ALLRED)) - 1;
  localparam int PW     = (PH_MAX > 0) ? $clog2(PH_MAX + 1) : 1;

  tlc_state_t    state;
  logic [PW-1:0] phase;
  logic          tick;
  logic          others;
  logic          leave;

  // First set request searching upward from last+1, wrapping; last has lowest priority.
  function automatic logic [1:0] rr_pick(logic [3:0] r, logic [1:0] last);
    logic [1:0] win;
    logic [1:0] idx;
    win = last;
    for (int k = 4; k >= 1; k--) begin
      idx = last + k[1:0];
      if (r[idx])
        win = idx;
    end
    return win;
  endfunction

  iiitb_tlc_tick #(
    .TICK_DIV (TICK_DIV)
  ) u_tick (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (leave),
    .tick  (tick)
  );

  assign others = |(req & ~(4'b0001 << grant));

  always_comb begin
    leave = 1'b0;
    case (state)
      S_IDLE:   leave = |req;
      S_GREEN:  leave = tick && others &&
                        ((phase == PW'(T_GMIN - 1) && !req[grant]) ||
                         (phase >= PW'(T_GMAX - 1)));
      S_YELLOW: leave = tick && (phase == PW'(T_YEL - 1));
      S_ALLRED: leave = tick && (phase == PW'(T_ALLRED - 1));
      default:  leave = 1'b1;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_IDLE;
      grant <= 2'd0;
      phase <= '0;
      light <= {4{RED}};
      busy  <= 1'b0;
    end else begin
      light <= light_decode(state, grant);
      busy  <= (state != S_IDLE);
      if (leave) begin
        phase <= '0;
        case (state)
          S_IDLE: begin
            state <= S_GREEN;
            grant <= rr_pick(req, grant);
          end
          S_GREEN:  state <= S_YELLOW;
          S_YELLOW: state <= S_ALLRED;
          S_ALLRED: begin
            if (|req) begin
              state <= S_GREEN;
              grant <= rr_pick(req, grant);
            end else begin
              state <= S_IDLE;
            end
          end
          default:  state <= S_IDLE;
        endcase
      end else if (tick && (phase != PW'(PH_MAX))) begin
        phase <= phase + PW'(1);
      end
    end
  end

endmodule

// File: tb/tb_iiitb_tlc_sched.sv
// Bench for iiitb_tlc_sched: cycle-level behavioural model plus directed
// timing scenarios and a randomized request run.
module tb_iiitb_tlc_sched;

  localparam int TD     = 4;
  localparam int T_GMIN = 5;
  localparam int T_GMAX = 10;
  localparam int T_YEL  = 3;
  localparam int T_AR   = 1;

  localparam logic [11:0] ALL_RED = 12'b100100100100;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [11:0] light;
  logic [1:0]  grant;
  logic        busy;

  int tests = 0;
  int fails = 0;

  iiitb_tlc_sched #(
    .TICK_DIV (TD),
    .T_GMIN   (T_GMIN),
    .T_GMAX   (T_GMAX),
    .T_YEL    (T_YEL),
    .T_ALLRED (T_AR)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req),
    .light (light),
    .grant (grant),
    .busy  (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: 0 idle, 1 green, 2 yellow, 3 all-red; phase time in raw clk cycles.
  int m_st, m_g, m_cyc, m_ost, m_og;

  function automatic logic [11:0] pat_of(int st, int g);
    logic [11:0] p;
    p = ALL_RED;
    if (st == 1) p[3*g +: 3] = 3'b001;
    if (st == 2) p[3*g +: 3] = 3'b010;
    return p;
  endfunction

  function automatic int rr_next(logic [3:0] r, int last);
    for (int k = 1; k <= 4; k++)
      if (r[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  always @(posedge clk or negedge rst_n) begin
    int e, nt;
    bit lv, oth;
    logic [3:0] r;
    if (!rst_n) begin
      m_st = 0; m_g = 0; m_cyc = 0; m_ost = 0; m_og = 0;
    end else begin
      r = req;
      m_ost = m_st;
      m_og  = m_g;
      e  = m_cyc + 1;
      nt = (e % TD == 0) ? e / TD : -1;
      oth = 1'b0;
      for (int i = 0; i < 4; i++) if (i != m_g && r[i]) oth = 1'b1;
      lv = 1'b0;
      case (m_st)
        0: lv = (r != 4'b0);
        1: lv = oth && ((nt == T_GMIN && !r[m_g]) || nt >= T_GMAX);
        2: lv = (nt == T_YEL);
        default: lv = (nt == T_AR);
      endcase
      if (lv) begin
        m_cyc = 0;
        if (m_st == 0 || (m_st == 3 && r != 4'b0)) begin
          m_g = rr_next(r, m_g);
          m_st = 1;
        end else if (m_st == 3) begin
          m_st = 0;
        end else begin
          m_st = m_st + 1;
        end
      end else begin
        m_cyc = m_cyc + 1;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h required %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      chk("model_light", 32'(light), 32'(pat_of(m_ost, m_og)));
      chk("model_grant", 32'(grant), 32'(m_g));
      chk("model_busy",  32'(busy),  32'(m_ost != 0));
    end
  end

  task automatic do_reset;
    req = 4'b0;
    @(negedge clk);
    #2 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_for(input logic [11:0] pat, input string name);
    int k;
    k = 0;
    while (light !== pat && k < 2000) begin
      k++;
      @(negedge clk);
    end
    if (light !== pat) begin
      tests++;
      fails++;
      $display("FAIL %s timeout: light=%b required %b", name, light, pat);
    end
  endtask

  task automatic count_run(input logic [11:0] pat, input int bound, output int n);
    n = 0;
    while (light === pat && n < bound) begin
      n++;
      @(negedge clk);
    end
  endtask

  initial begin
    int n;
    int seq [5];
    rst_n = 1'b1;
    req   = 4'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("reset_light", 32'(light), 32'(ALL_RED));
    chk("reset_grant", 32'(grant), 32'd0);
    chk("reset_busy",  32'(busy),  32'd0);

    // Single request held: one-cycle output lag, then green indefinitely.
    do_reset;
    req = 4'b0001;
    @(negedge clk);
    chk("s1_lag_light", 32'(light), 32'(ALL_RED));
    chk("s1_lag_busy",  32'(busy),  32'd0);
    @(negedge clk);
    chk("s1_green", 32'(light), 32'(12'b100100100001));
    chk("s1_busy",  32'(busy),  32'd1);
    count_run(12'b100100100001, 200, n);
    chk("s1_hold200", 32'(n), 32'd200);

    // Competing request: max green, yellow, all-red, then approach 2.
    do_reset;
    req = 4'b0001;
    wait_for(12'b100100100001, "s2_green0");
    req = 4'b0101;
    count_run(12'b100100100001, 500, n);
    chk("s2_green_len", 32'(n), 32'd40);
    count_run(12'b100100100010, 500, n);
    chk("s2_yel_len", 32'(n), 32'd12);
    count_run(ALL_RED, 500, n);
    chk("s2_allred_len", 32'(n), 32'd4);
    chk("s2_next_light", 32'(light), 32'(12'b100001100100));
    chk("s2_next_grant", 32'(grant), 32'd2);

    // Own request dropped with another pending: min green, then back to idle.
    do_reset;
    req = 4'b0001;
    wait_for(12'b100100100001, "s3_green0");
    req = 4'b0010;
    count_run(12'b100100100001, 500, n);
    chk("s3_green_len", 32'(n), 32'd20);
    req = 4'b0000;
    count_run(12'b100100100010, 500, n);
    chk("s3_yel_len", 32'(n), 32'd12);
    repeat (20) @(negedge clk);
    chk("s3_idle_light", 32'(light), 32'(ALL_RED));
    chk("s3_idle_busy",  32'(busy),  32'd0);
    chk("s3_idle_grant", 32'(grant), 32'd0);

    // All requests held: strict rotation.
    do_reset;
    req = 4'b0001;
    wait_for(12'b100100100001, "s4_start");
    req = 4'b1111;
    seq = '{0, 1, 2, 3, 0};
    for (int i = 0; i < 5; i++) begin
      wait_for(pat_of(1, seq[i]), "s4_rot");
      chk("s4_grant", 32'(grant), 32'(seq[i]));
      count_run(pat_of(1, seq[i]), 500, n);
      chk("s4_green_len", 32'(n), 32'd40);
    end

    // Asynchronous reset in the middle of yellow.
    do_reset;
    req = 4'b0001;
    wait_for(12'b100100100001, "s5_green0");
    req = 4'b0011;
    wait_for(12'b100100100010, "s5_yellow");
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("s5_async_light", 32'(light), 32'(ALL_RED));
    chk("s5_async_grant", 32'(grant), 32'd0);
    chk("s5_async_busy",  32'(busy),  32'd0);
    #2 rst_n = 1'b1;

    // Randomized requests checked by the model every cycle.
    do_reset;
    for (int c = 0; c < 6000; c++) begin
      @(negedge clk);
      if ($urandom_range(0, 15) == 0)
        req = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0 && c % 500 == 250)
        req = 4'b0000;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/iiitb_tlc_sched.md
IIITB_TLC_SCHED -- requirements
Module: iiitb_tlc_sched

Interface
REQ-001 The block SHALL have parameter TICK_DIV, default 4, giving clk cycles per timing tick (50000000 on FPGA).
REQ-002 The block SHALL have parameter T_GMIN, default 5, giving the minimum green time in ticks.
REQ-003 The block SHALL have parameter T_GMAX, default 10, giving the maximum green time in ticks while another approach is waiting.
REQ-004 The block SHALL have parameter T_YEL, default 3, giving the yellow time in ticks.
REQ-005 The block SHALL have parameter T_ALLRED, default 1, giving the all-red clearance time in ticks.
REQ-006 clk  input  1  single system clock; all state changes on posedge.
REQ-007 rst_n  input  1  asynchronous, active-low reset.
REQ-008 req  input  4  per-approach vehicle sensor levels; bit i is approach i.
REQ-009 light  output  12  three bits per approach, [3i+2:3i]; red=100, yellow=010, green=001.
REQ-010 grant  output  2  index of the approach holding or last holding right-of-way.
REQ-011 busy  output  1  high in GREEN, YELLOW and ALLRED; low in IDLE.

Function
REQ-012 The FSM SHALL have exactly four states: IDLE, GREEN, YELLOW and ALLRED.
REQ-013 All outputs SHALL be registered and decoded from the state and grant.
- IDLE and ALLRED: all approaches red.
- GREEN: approach grant 001, others 100.
- YELLOW: approach grant 010, others 100.
REQ-014 An internal prescaler SHALL count 0..TICK_DIV-1 and pulse tick at TICK_DIV-1.
- The prescaler and the phase counter SHALL clear on every state change.
- A phase of T ticks therefore SHALL last exactly T*TICK_DIV clk cycles.
REQ-015 The phase counter SHALL be wide enough for T_GMAX-1, SHALL increment on tick, and SHALL saturate rather than wrap.
REQ-016 From IDLE, any req bit sampled high at edge k SHALL move the FSM to GREEN, with light valid at edge k+1.
- The granted approach SHALL be chosen round-robin: first set bit searching from (grant+1) mod 4 upward, wrapping.
REQ-017 The "others pending" condition SHALL mean any req bit set other than req[grant].
REQ-018 GREEN SHALL exit to YELLOW on the tick that completes the phase, under either condition:
- phase count = T_GMIN-1, others pending, and req[grant]=0; or
- phase count >= T_GMAX-1 and others pending.
REQ-019 GREEN with no other request pending SHALL hold indefinitely, regardless of the phase count.
REQ-020 YELLOW SHALL go to ALLRED after T_YEL ticks.
REQ-021 ALLRED SHALL end after T_ALLRED ticks:
- to GREEN on the round-robin winner if any req is set; grant updates on that same edge;
- otherwise to IDLE.
REQ-022 Requests that fall during YELLOW or ALLRED SHALL NOT be latched; arbitration uses req sampled on the exit edge only.
REQ-023 If req[grant] rises again during YELLOW, the sequence SHALL still complete; the same approach wins only by round-robin order.
REQ-024 Illegal state encodings SHALL recover to IDLE on the next edge.

Reset
REQ-025 On rst_n low the block SHALL immediately set: state IDLE, grant 0, busy 0, light 12'b100100100100, and both counters 0.
REQ-026 The block SHALL leave reset on the first posedge clk with rst_n high.
- Assertion of rst_n mid-phase SHALL abandon the phase with no yellow step.

Structure
REQ-027 State encodings and light codes (RED, YEL, GRN) SHALL live in shared package iiitb_tlc_pkg, reused by iiitb_tlc.
REQ-028 The prescaler SHALL be sub-module iiitb_tlc_tick with ports clk, rst_n, clr and tick.
REQ-029 The round-robin picker SHALL be a combinational function in the block.

Verification (defaults: TICK_DIV=4, cycles in clk)
REQ-030 Reset check: assert rst_n low mid-YELLOW -> light=12'b100100100100, grant=0, busy=0 without waiting for a clock edge.
REQ-031 req=0001 from cycle 10, held -> approach 0 green from cycle 11, unchanged for 200 cycles, busy=1.
REQ-032 req0 held and req2 rising at green start -> 40 cycles green, then 12 cycles yellow, then 4 cycles all-red, then grant=2 green.
REQ-033 req0 drops after green start with req1 pending -> green lasts exactly 20 cycles, then yellow.
REQ-034 req=1111 held -> grant sequence 0,1,2,3,0, each green 40 cycles.
REQ-035 req0 pulse only, dropped before ALLRED ends -> sequence returns to IDLE, all red, busy=0.
